// File: rtl/ysyx_22041207_cache_pkg.sv
// Shared types and constants for the cache sequencing controller.
package ysyx_22041207_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        BYPASS,
        WRITE,
        RESP
    } state_e;

    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;

    localparam int LINE_OFF_W = 3;

    localparam logic [63:0] MMIO_BASE_DEF = 64'h0000_0000_A000_0000;

    function automatic logic [63:0] line_align(input logic [63:0] a);
        return {a[63:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/ysyx_22041207_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the port that wins a tie.
module ysyx_22041207_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       idx
);

    logic ptr;

    always_comb begin
        idx   = (&valid) ? ptr : valid[1];
        grant = 2'b00;
        if (en && |valid) begin
            grant = idx ? 2'b10 : 2'b01;
        end
    end

    // After a grant the loser gets the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b1;
        end else if (|grant) begin
            ptr <= ~idx;
        end
    end

endmodule

// File: rtl/ysyx_22041207_cache_ctrl.sv
// Arbitrates IFU/LSU onto the cache and memory bus: hit lookup,
// refill, write-through with invalidate, and uncached MMIO bypass.
module ysyx_22041207_cache_ctrl
    import ysyx_22041207_cache_pkg::*;
#(
    parameter logic [63:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_addr,
    input  logic [1:0]   req_wen,
    input  logic [127:0] req_wdata,
    input  logic [15:0]  req_wmask,
    output logic [1:0]   resp_valid,
    output logic [63:0]  resp_data,
    output logic [63:0]  c_raddr,
    input  logic         c_hit,
    input  logic [63:0]  c_rdata,
    output logic         c_fill,
    output logic [63:0]  c_fill_addr,
    output logic [63:0]  c_fill_data,
    output logic         c_inv,
    output logic [63:0]  c_inv_addr,
    output logic [63:0]  c_inv_data,
    output logic [7:0]   c_inv_mask,
    output logic         mem_req,
    output logic         mem_wen,
    output logic [63:0]  mem_addr,
    output logic [63:0]  mem_wdata,
    output logic [7:0]   mem_wmask,
    input  logic         mem_ack,
    input  logic [63:0]  mem_rdata
);

    state_e      state_q, state_d;
    logic        port_q;
    logic [63:0] addr_q;
    logic        mmio_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic        first_q;
    logic [63:0] data_q;

    logic [1:0]  grant;
    logic        gidx;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic [7:0]  sel_wmask;
    logic        sel_wen;
    logic        sel_mmio;

    ysyx_22041207_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == IDLE),
        .valid (req_valid),
        .grant (grant),
        .idx   (gidx)
    );

    assign sel_addr  = gidx ? req_addr[127:64]  : req_addr[63:0];
    assign sel_wdata = gidx ? req_wdata[127:64] : req_wdata[63:0];
    assign sel_wmask = gidx ? req_wmask[15:8]   : req_wmask[7:0];
    assign sel_wen   = gidx ? req_wen[1]        : req_wen[0];
    assign sel_mmio  = sel_addr >= MMIO_BASE;

    assign resp_data = data_q;

    always_comb begin
        state_d     = state_q;
        req_ready   = 2'b00;
        resp_valid  = 2'b00;
        c_raddr     = '0;
        c_fill      = 1'b0;
        c_fill_addr = '0;
        c_fill_data = '0;
        c_inv       = 1'b0;
        c_inv_addr  = '0;
        c_inv_data  = '0;
        c_inv_mask  = '0;
        mem_req     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    if (sel_wen)       state_d = WRITE;
                    else if (sel_mmio) state_d = BYPASS;
                    else               state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                c_raddr = addr_q;
                state_d = c_hit ? RESP : REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = line_align(addr_q);
                if (mem_ack) begin
                    c_fill      = 1'b1;
                    c_fill_addr = line_align(addr_q);
                    c_fill_data = mem_rdata;
                    state_d     = RESP;
                end
            end
            BYPASS: begin
                mem_req  = 1'b1;
                mem_addr = line_align(addr_q);
                if (mem_ack) state_d = RESP;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask_q;
                // Write-through, no-allocate: drop the line once.
                if (first_q && !mmio_q) begin
                    c_inv      = 1'b1;
                    c_inv_addr = addr_q;
                    c_inv_data = wdata_q;
                    c_inv_mask = wmask_q;
                end
                if (mem_ack) state_d = RESP;
            end
            RESP: begin
                resp_valid[IFU] = (port_q == IFU);
                resp_valid[LSU] = (port_q == LSU);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            port_q  <= IFU;
            addr_q  <= '0;
            mmio_q  <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            first_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q == IDLE);
            if (state_q == IDLE && |grant) begin
                port_q  <= gidx;
                addr_q  <= sel_addr;
                mmio_q  <= sel_mmio;
                wdata_q <= sel_wdata;
                wmask_q <= sel_wmask;
            end
            if (state_q == LOOKUP && c_hit) begin
                data_q <= c_rdata;
            end
            if ((state_q == REFILL || state_q == BYPASS) && mem_ack) begin
                data_q <= mem_rdata;
            end
            if (state_q == WRITE && mem_ack) begin
                data_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_cache_ctrl.sv
// Directed bench for the cache controller with a response scoreboard,
// a latency-programmable bus model and an address-keyed cache model.
module tb_ysyx_22041207_cache_ctrl;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_addr;
    logic [1:0]   req_wen;
    logic [127:0] req_wdata;
    logic [15:0]  req_wmask;
    logic [1:0]   resp_valid;
    logic [63:0]  resp_data;
    logic [63:0]  c_raddr;
    logic         c_hit;
    logic [63:0]  c_rdata;
    logic         c_fill;
    logic [63:0]  c_fill_addr;
    logic [63:0]  c_fill_data;
    logic         c_inv;
    logic [63:0]  c_inv_addr;
    logic [63:0]  c_inv_data;
    logic [7:0]   c_inv_mask;
    logic         mem_req;
    logic         mem_wen;
    logic [63:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [7:0]   mem_wmask;
    logic         mem_ack;
    logic [63:0]  mem_rdata;

    ysyx_22041207_cache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wen     (req_wen),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .c_raddr     (c_raddr),
        .c_hit       (c_hit),
        .c_rdata     (c_rdata),
        .c_fill      (c_fill),
        .c_fill_addr (c_fill_addr),
        .c_fill_data (c_fill_data),
        .c_inv       (c_inv),
        .c_inv_addr  (c_inv_addr),
        .c_inv_data  (c_inv_data),
        .c_inv_mask  (c_inv_mask),
        .mem_req     (mem_req),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    typedef struct packed {
        logic        p;
        logic [63:0] d;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_m;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [63:0] rd_key;
    logic        hit_en;
    int          lat;
    int          wcnt;
    logic [63:0] bus_data;

    int          resp_tot = 0;
    int          resp_cnt[2];
    int          last_resp_cyc;
    int          fill_cnt = 0;
    int          inv_cnt = 0;
    int          req_cyc_cnt = 0;
    int          last_fill_cyc;
    int          last_inv_cyc;
    int          rise_cyc;
    int          ack_cyc;
    logic [63:0] fill_addr, fill_data, inv_addr, inv_data, rise_addr;
    logic [7:0]  inv_mask, rise_mask;
    logic        rise_wen;
    logic        prev_req = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @* begin
        c_hit   = hit_en;
        c_rdata = c_raddr ^ rd_key;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus slave: acks lat cycles after a request is first seen.
    always @(posedge clk) begin
        #2;
        if (mem_req && !mem_ack) begin
            if (wcnt == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = bus_data;
            end else begin
                wcnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            wcnt      = 0;
        end
    end

    always @(negedge clk) begin
        if (resp_valid != 2'b00) begin
            last_resp_cyc = cyc;
            resp_tot++;
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e_m = sb.pop_front();
                chk("resp_port", 64'(resp_valid), e_m.p ? 64'd2 : 64'd1);
                chk("resp_data", resp_data, e_m.d);
                resp_cnt[e_m.p]++;
            end
        end
        if (c_fill) begin
            fill_cnt++;
            last_fill_cyc = cyc;
            fill_addr = c_fill_addr;
            fill_data = c_fill_data;
        end
        if (c_inv) begin
            inv_cnt++;
            last_inv_cyc = cyc;
            inv_addr = c_inv_addr;
            inv_data = c_inv_data;
            inv_mask = c_inv_mask;
        end
        if (mem_req && !prev_req) begin
            rise_cyc  = cyc;
            rise_addr = mem_addr;
            rise_wen  = mem_wen;
            rise_mask = mem_wmask;
        end
        if (mem_req) req_cyc_cnt++;
        if (mem_req && mem_ack) ack_cyc = cyc;
        prev_req = mem_req;
    end

    task automatic issue(input int p, input logic [63:0] a,
                         input logic w, input logic [63:0] d,
                         input logic [7:0] m, output int t);
        @(negedge clk);
        req_addr[p*64 +: 64] = a;
        req_wdata[p*64 +: 64] = d;
        req_wmask[p*8 +: 8] = m;
        req_wen[p] = w;
        req_valid[p] = 1'b1;
        #1;
        t = -1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[p]) begin
                t = cyc;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (t < 0) chk("grant_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_resp(input int n, input string tag);
        int i = 0;
        while (resp_tot < n && i < 60) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (resp_tot < n) chk({tag, "_timeout"}, 64'(resp_tot), 64'(n));
    endtask

    initial begin
        int t, r0, f0, i0, c0, c1, tp, p, k, n;
        logic [63:0] a0, a1;
        resp_cnt[0] = 0;
        resp_cnt[1] = 0;
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_wen = '0;
        req_wdata = '0;
        req_wmask = '0;
        hit_en = 1'b0;
        rd_key = '0;
        lat = 1;
        bus_data = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        wcnt = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_c_fill", 64'(c_fill), 64'd0);
        chk("rst_c_inv", 64'(c_inv), 64'd0);
        chk("rst_c_raddr", c_raddr, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Port 1 cached load hit
        hit_en = 1'b1;
        rd_key = 64'h8000_0010 ^ 64'hDEAD;
        r0 = req_cyc_cnt;
        sb.push_back('{p: 1'b1, d: 64'hDEAD});
        issue(1, 64'h8000_0010, 1'b0, 64'd0, 8'd0, t);
        wait_resp(1, "t1");
        chk("t1_resp_cycle", 64'(last_resp_cyc), 64'(t + 2));
        chk("t1_no_mem_req", 64'(req_cyc_cnt), 64'(r0));

        // Port 0 load miss with refill
        hit_en = 1'b0;
        lat = 3;
        bus_data = 64'h1234;
        f0 = fill_cnt;
        sb.push_back('{p: 1'b0, d: 64'h1234});
        issue(0, 64'h8000_0013, 1'b0, 64'd0, 8'd0, t);
        wait_resp(2, "t2");
        chk("t2_req_rise", 64'(rise_cyc), 64'(t + 2));
        chk("t2_mem_addr", rise_addr, 64'h8000_0010);
        chk("t2_mem_wen", 64'(rise_wen), 64'd0);
        chk("t2_ack_delay", 64'(ack_cyc), 64'(rise_cyc + 3));
        chk("t2_fill_cnt", 64'(fill_cnt), 64'(f0 + 1));
        chk("t2_fill_addr", fill_addr, 64'h8000_0010);
        chk("t2_fill_data", fill_data, 64'h1234);
        chk("t2_fill_cycle", 64'(last_fill_cyc), 64'(ack_cyc));
        chk("t2_resp_cycle", 64'(last_resp_cyc), 64'(ack_cyc + 1));

        // Port 1 cached store
        lat = 1;
        bus_data = 64'h0BAD;
        i0 = inv_cnt;
        f0 = fill_cnt;
        sb.push_back('{p: 1'b1, d: 64'd0});
        issue(1, 64'h8000_0008, 1'b1, 64'hFF, 8'h01, t);
        wait_resp(3, "t3");
        chk("t3_inv_cnt", 64'(inv_cnt), 64'(i0 + 1));
        chk("t3_inv_addr", inv_addr, 64'h8000_0008);
        chk("t3_inv_mask", 64'(inv_mask), 64'h01);
        chk("t3_inv_data", inv_data, 64'hFF);
        chk("t3_inv_cycle", 64'(last_inv_cyc), 64'(t + 1));
        chk("t3_req_rise", 64'(rise_cyc), 64'(t + 1));
        chk("t3_mem_wen", 64'(rise_wen), 64'd1);
        chk("t3_mem_wmask", 64'(rise_mask), 64'h01);
        chk("t3_mem_addr", rise_addr, 64'h8000_0008);
        chk("t3_no_fill", 64'(fill_cnt), 64'(f0));
        chk("t3_resp_cycle", 64'(last_resp_cyc), 64'(ack_cyc + 1));

        // Port 0 MMIO load bypass; a cache hit must be ignored
        hit_en = 1'b1;
        rd_key = 64'h1;
        lat = 2;
        bus_data = 64'h5555_AAAA;
        i0 = inv_cnt;
        f0 = fill_cnt;
        sb.push_back('{p: 1'b0, d: 64'h5555_AAAA});
        issue(0, 64'hA000_0000, 1'b0, 64'd0, 8'd0, t);
        wait_resp(4, "t4");
        chk("t4_req_rise", 64'(rise_cyc), 64'(t + 1));
        chk("t4_mem_addr", rise_addr, 64'hA000_0000);
        chk("t4_no_fill", 64'(fill_cnt), 64'(f0));
        chk("t4_no_inv", 64'(inv_cnt), 64'(i0));
        chk("t4_resp_cycle", 64'(last_resp_cyc), 64'(ack_cyc + 1));

        // Both ports requesting continuously
        hit_en = 1'b1;
        rd_key = 64'h1111;
        a0 = 64'h8000_0100;
        a1 = 64'h8000_0200;
        c0 = resp_cnt[0];
        c1 = resp_cnt[1];
        n = resp_tot;
        @(negedge clk);
        req_addr = {a1, a0};
        req_wen = 2'b00;
        req_valid = 2'b11;
        #1;
        tp = 0;
        for (k = 0; k < 4; k++) begin
            t = -1;
            for (int i = 0; i < 20; i++) begin
                if (req_ready != 2'b00) begin
                    t = cyc;
                    break;
                end
                @(negedge clk);
                #1;
            end
            if (t < 0) begin
                chk("t5_grant_timeout", 64'd0, 64'd1);
                break;
            end
            p = req_ready[1] ? 1 : 0;
            chk("t5_grant_order", 64'(req_ready), (k % 2 == 0) ? 64'd2 : 64'd1);
            sb.push_back('{p: p[0], d: (p == 1 ? a1 : a0) ^ rd_key});
            if (k > 0) chk("t5_interval", 64'(t - tp), 64'd3);
            tp = t;
            if (k == 3) begin
                @(posedge clk);
                #1;
                req_valid = 2'b00;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        wait_resp(n + 4, "t5");
        chk("t5_resp_port0", 64'(resp_cnt[0]), 64'(c0 + 2));
        chk("t5_resp_port1", 64'(resp_cnt[1]), 64'(c1 + 2));

        // Reset while refilling
        hit_en = 1'b0;
        lat = 10;
        issue(1, 64'h8000_0040, 1'b0, 64'd0, 8'd0, t);
        k = 0;
        while (!mem_req && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t6_in_refill", 64'(mem_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_req_drop", 64'(mem_req), 64'd0);
        chk("t6_no_resp", 64'(resp_valid), 64'd0);
        r0 = resp_tot;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("t6_no_resp_after", 64'(resp_tot), 64'(r0));
        chk("t6_idle_bus", 64'(mem_req), 64'd0);

        hit_en = 1'b1;
        rd_key = 64'h77;
        sb.push_back('{p: 1'b0, d: 64'h8000_0018 ^ 64'h77});
        issue(0, 64'h8000_0018, 1'b0, 64'd0, 8'd0, t);
        wait_resp(r0 + 1, "t6b");
        chk("t6b_resp_cycle", 64'(last_resp_cyc), 64'(t + 2));
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_cache_ctrl.md
# ysyx_22041207_cache_ctrl

Sequencing and arbitration controller for the core's single-port 64-bit direct-mapped data/instruction cache. Two requesters share the cache: instruction fetch (port 0) and load/store unit (port 1). The controller performs hit lookup, miss refill from the memory bus, write-through with line invalidation, and uncached MMIO bypass. It sits between the IFU/LSU and both the cache array and the memory bus master.

## Interface
- `MMIO_BASE`, default 64'h0000_0000_A000_0000: addresses >= this bypass the cache (no lookup, no refill).
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-port request valid; held until granted.
- `req_ready`  out  2  per-port one-cycle grant pulse; request is accepted in that cycle.
- `req_addr`  in  2x64  byte address per port; stable while valid.
- `req_wen`  in  2  1 = store, 0 = load.
- `req_wdata`  in  2x64  store data, 8-byte-lane aligned.
- `req_wmask`  in  2x8  store byte mask.
- `resp_valid`  out  2  one-cycle response pulse to the granted port.
- `resp_data`  out  64  load data; 0 for stores; valid only with `resp_valid`.
- `c_raddr`  out  64  cache `readAddress`.
- `c_hit`  in  1  cache `readHit` (combinational on `c_raddr`).
- `c_rdata`  in  64  cache `readData`.
- `c_fill`, `c_fill_addr`, `c_fill_data`  out  1/64/64  cache refill strobe, address, data.
- `c_inv`, `c_inv_addr`, `c_inv_data`, `c_inv_mask`  out  1/64/64/8  cache store-update strobe, address, data, mask.
- `mem_req`  out  1  bus request; held until `mem_ack`.
- `mem_wen`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/64/64/8  bus command, stable while `mem_req`.
- `mem_ack`  in  1  bus completion; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  64  bus read data.

## Operation
- FSM states: IDLE, LOOKUP, REFILL, BYPASS, WRITE, RESP. Reset state IDLE.
- IDLE: if any `req_valid`, arbitrate, pulse `req_ready` for the winner, latch port/addr/wen/wdata/wmask, then go to LOOKUP (cached load), BYPASS (addr >= MMIO_BASE load), or WRITE (any store).
- Arbitration: round-robin with a 1-bit priority pointer; reset value favours port 1. After every grant the pointer points to the non-granted port. A single requester is always granted immediately.
- LOOKUP: `c_raddr` = latched addr. If `c_hit`, capture `c_rdata` and go to RESP; otherwise go to REFILL.
- REFILL: `mem_req`=1, `mem_wen`=0, `mem_addr` = addr with bits [2:0] cleared. On `mem_ack`: one-cycle `c_fill` with `c_fill_addr` = aligned addr and `c_fill_data` = `mem_rdata`; capture data; go to RESP.
- BYPASS: identical bus read without `c_fill`.
- WRITE: for a cached store, pulse `c_inv` in the first WRITE cycle (write-through, no-allocate; line invalidated). Hold `mem_req`=1, `mem_wen`=1 with latched addr/data/mask until `mem_ack`, then go to RESP. An MMIO store does not assert `c_inv`.
- RESP: one-cycle `resp_valid` to the latched port; then IDLE. No new grant occurs in RESP.
- Only one transaction is outstanding; the requester not granted keeps `req_valid` high and waits.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `c_fill`=0, `c_inv`=0, `mem_req`=0, `mem_wen`=0, and all address/data outputs 0. The priority pointer is set to port 1.
- Accept at cycle T. Hit: `resp_valid` at T+2.
- Miss/bypass/store: `mem_req` rises at T+2 (miss) or T+1 (bypass/store). The first `mem_ack` cycle is A; `resp_valid` is at A+1. `c_fill` is asserted at cycle A.
- Back-to-back: the next grant is no earlier than the cycle after RESP. Minimum issue interval is 3 cycles.
- `mem_ack` is ignored when `mem_req`=0.
- Reset asserted mid-transaction returns the FSM to IDLE asynchronously and drops `mem_req`. The bus tolerates the abandoned request. No `resp_valid` is issued for the aborted request.

## Structure
- Shared package `ysyx_22041207_cache_pkg` holds:
  - the state enum;
  - the port index constants IFU=0 and LSU=1;
  - `LINE_OFF_W`=3;
  - the `MMIO_BASE` default.
- One sub-module, `ysyx_22041207_rr_arb2`, implements the 2-way round-robin arbiter with the pointer register. The rest of the control stays in one FSM.

## Test plan
- Port 1 load 0x8000_0010, cache hits with `c_rdata`=0xDEAD → `req_ready[1]` at T, `resp_valid[1]` at T+2 with `resp_data`=0xDEAD, `mem_req` never asserted.
- Port 0 load 0x8000_0013, miss, `mem_ack` 3 cycles after `mem_req` with 0x1234 → `mem_addr`=0x8000_0010, `c_fill` pulse with that address/data, `resp_data`=0x1234.
- Port 1 store 0x8000_0008, data 0xFF, mask 0x01 → `c_inv` pulse with `c_inv_addr`=0x8000_0008 and `c_inv_mask`=0x01, bus write with `mem_wmask`=0x01, `resp_data`=0.
- Load at 0xA000_0000 → `mem_req` at T+1, no `c_inv`/`c_fill`, response with bus data.
- Both ports valid continuously → grants in order 1,0,1,0; each port receives exactly one response per grant.
- `rst` pulse while in REFILL → `mem_req` drops immediately, no `resp_valid`, and a fresh request afterwards completes normally.
